// File: rtl/hmc_bus_pkg.sv
// hmc_bus_pkg: shared arbiter state encoding and bus-owner constants.
package hmc_bus_pkg;
  typedef enum logic [1:0] {CORE, HALT, DMA, TURN} arb_state_e;
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
endpackage

// File: rtl/arb_counter.sv
// arb_counter: 8-bit loadable up/down counter that saturates at LIMIT and flags it.
module arb_counter #(
  parameter bit UP = 1'b1,
  parameter logic [7:0] LIMIT = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       tc
);
  logic [7:0] count;
  assign tc = count == LIMIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (en && !tc) count <= UP ? count + 8'd1 : count - 8'd1;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the memory bus between the 6502 core and one DMA requester,
// stalling the core via RDY only on reads and bounding DMA bursts.
module bus_arbiter
  import hmc_bus_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int MIN_CORE = 2
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] core_address,
  input  logic [7:0]  core_data_out,
  input  logic        core_read_en,
  output logic        core_rdy,
  output logic [7:0]  core_data_in,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_data_out,
  input  logic        dma_read_en,
  output logic        dma_gnt,
  output logic [7:0]  dma_data_in,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_out,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_in,
  output logic        bus_owner
);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] COOL_LOAD = 8'(MIN_CORE);
  arb_state_e state, next;
  logic burst_tc, cool_tc;
  arb_counter #(.UP(1'b1), .LIMIT(BURST_LAST)) u_burst (
    .clk(ph1), .rst_n(reset), .load(state == HALT && dma_req), .en(state == DMA),
    .load_val(8'd0), .tc(burst_tc)
  );
  arb_counter #(.UP(1'b0), .LIMIT(8'd0)) u_cool (
    .clk(ph1), .rst_n(reset), .load(state == TURN), .en(state == CORE),
    .load_val(COOL_LOAD), .tc(cool_tc)
  );
  always_ff @(posedge ph1 or negedge reset)
    if (!reset) state <= CORE;
    else state <= next;
  // A write cycle can never be frozen, so a halt only starts on a core read.
  always_comb begin
    next = state;
    case (state)
      CORE: next = dma_req && cool_tc && core_read_en ? HALT : CORE;
      HALT: next = dma_req ? DMA : TURN;
      DMA:  next = !dma_req || burst_tc ? TURN : DMA;
      default: next = CORE;
    endcase
  end
  assign core_rdy = state == CORE;
  assign dma_gnt = state == DMA;
  assign bus_owner = dma_gnt ? OWNER_DMA : OWNER_CORE;
  assign mem_address = bus_owner == OWNER_DMA ? dma_address : core_address;
  assign mem_data_out = bus_owner == OWNER_DMA ? dma_data_out : core_data_out;
  assign mem_read_en = bus_owner == OWNER_DMA ? dma_read_en : core_read_en | (state == HALT);
  assign core_data_in = mem_data_in;
  assign dma_data_in = mem_data_in;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (MAX_BURST=4, MIN_CORE=2).
module tb_bus_arbiter;
  logic ph1, reset;
  logic [15:0] core_address, dma_address, mem_address;
  logic [7:0] core_data_out, core_data_in, dma_data_out, dma_data_in, mem_data_out, mem_data_in;
  logic core_read_en, core_rdy, dma_req, dma_read_en, dma_gnt, mem_read_en, bus_owner;
  int n_assert = 0;
  int n_fail = 0;
  int n;
  bus_arbiter #(.MAX_BURST(4), .MIN_CORE(2)) dut (
    .ph1(ph1), .reset(reset),
    .core_address(core_address), .core_data_out(core_data_out), .core_read_en(core_read_en),
    .core_rdy(core_rdy), .core_data_in(core_data_in),
    .dma_req(dma_req), .dma_address(dma_address), .dma_data_out(dma_data_out),
    .dma_read_en(dma_read_en), .dma_gnt(dma_gnt), .dma_data_in(dma_data_in),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_read_en(mem_read_en),
    .mem_data_in(mem_data_in), .bus_owner(bus_owner)
  );
  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ph1);
    #1;
  endtask
  initial begin
    reset = 1'b0;
    core_address = 16'h8000; core_data_out = 8'h00; core_read_en = 1'b1;
    dma_req = 1'b0; dma_address = 16'h0000; dma_data_out = 8'h00; dma_read_en = 1'b1;
    mem_data_in = 8'h3C;
    step(); step();
    chk("rst_rdy", 16'(core_rdy), 16'd1);
    chk("rst_gnt", 16'(dma_gnt), 16'd0);
    chk("rst_owner", 16'(bus_owner), 16'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_rdy", 16'(core_rdy), 16'd1);
      chk("idle_gnt", 16'(dma_gnt), 16'd0);
      chk("idle_addr", mem_address, 16'h8000);
    end
    chk("core_din", 16'(core_data_in), 16'h003C);
    chk("dma_din", 16'(dma_data_in), 16'h003C);
    core_address = 16'h0200; dma_req = 1'b1; dma_address = 16'h4014;
    step();
    chk("halt_rdy", 16'(core_rdy), 16'd0);
    chk("halt_gnt", 16'(dma_gnt), 16'd0);
    chk("halt_addr", mem_address, 16'h0200);
    chk("halt_rd", 16'(mem_read_en), 16'd1);
    step();
    chk("dma_gnt", 16'(dma_gnt), 16'd1);
    chk("dma_owner", 16'(bus_owner), 16'd1);
    chk("dma_addr", mem_address, 16'h4014);
    chk("dma_rdy", 16'(core_rdy), 16'd0);
    dma_req = 1'b0;
    step();
    chk("turn_gnt", 16'(dma_gnt), 16'd0);
    chk("turn_rdy", 16'(core_rdy), 16'd0);
    chk("turn_addr", mem_address, 16'h0200);
    step();
    chk("back_rdy", 16'(core_rdy), 16'd1);
    core_read_en = 1'b0; core_address = 16'h0300; core_data_out = 8'h5A; dma_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr_rdy", 16'(core_rdy), 16'd1);
      chk("wr_rd", 16'(mem_read_en), 16'd0);
      chk("wr_data", 16'(mem_data_out), 16'h005A);
    end
    core_read_en = 1'b1; core_address = 16'h0400;
    step();
    chk("rd_halt_rdy", 16'(core_rdy), 16'd0);
    chk("rd_halt_addr", mem_address, 16'h0400);
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!dma_gnt && n < 20) begin step(); n++; end
      chk("burst_wait", 16'(dma_gnt), 16'd1);
      n = 0;
      while (dma_gnt && n < 20) begin step(); n++; end
      chk("burst_len", 16'(n), 16'd4);
      chk("burst_turn_rdy", 16'(core_rdy), 16'd0);
      step();
      n = 0;
      while (core_rdy && n < 20) begin step(); n++; end
      chk("core_tenure", 16'(n), 16'd3);
      chk("rehalt_gnt", 16'(dma_gnt), 16'd0);
    end
    dma_req = 1'b0;
    step();
    chk("abort_rdy", 16'(core_rdy), 16'd0);
    chk("abort_gnt", 16'(dma_gnt), 16'd0);
    step();
    chk("abort_core_rdy", 16'(core_rdy), 16'd1);
    chk("abort_core_gnt", 16'(dma_gnt), 16'd0);
    core_address = 16'h0500;
    dma_req = 1'b1; dma_address = 16'h2004; dma_data_out = 8'hA5; dma_read_en = 1'b0;
    n = 0;
    while (!dma_gnt && n < 20) begin step(); n++; end
    chk("wr_dma_wait", 16'(dma_gnt), 16'd1);
    chk("wr_dma_addr", mem_address, 16'h2004);
    chk("wr_dma_data", 16'(mem_data_out), 16'h00A5);
    chk("wr_dma_rd", 16'(mem_read_en), 16'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_owner", 16'(bus_owner), 16'd0);
    chk("async_gnt", 16'(dma_gnt), 16'd0);
    chk("async_rdy", 16'(core_rdy), 16'd1);
    chk("async_addr", mem_address, 16'h0500);
    dma_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_rdy", 16'(core_rdy), 16'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single external memory bus between the 6502 core and one DMA requester.
- Stalls the core only on read cycles, using 6502 RDY semantics: the core can freeze on a read, never on a write.
- Grants the bus to DMA for bounded bursts and enforces a minimum core tenure between bursts.
- Sits between the core's address/data_out/read_en and the memory system.

Parameters:
- MAX_BURST, 16: maximum consecutive DMA-owned cycles per grant, 1..255.
- MIN_CORE, 2: minimum core-owned cycles after a DMA tenure before a new halt may begin, 0..255.

Ports:
- ph1  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- core_address  in  16  core bus address.
- core_data_out  in  8  core write data.
- core_read_en  in  1  core cycle type; 1=read, 0=write.
- core_rdy  out  1  0 freezes core; registered.
- core_data_in  out  8  mem_data_in forwarded to core.
- dma_req  in  1  DMA requests bus; level, held for whole burst.
- dma_address  in  16  DMA address.
- dma_data_out  in  8  DMA write data.
- dma_read_en  in  1  DMA cycle type.
- dma_gnt  out  1  DMA owns bus this cycle; registered.
- dma_data_in  out  8  mem_data_in forwarded to DMA.
- mem_address  out  16  muxed bus address.
- mem_data_out  out  8  muxed write data.
- mem_read_en  out  1  muxed cycle type.
- mem_data_in  in  8  memory read data.
- bus_owner  out  1  0=core, 1=DMA.

Behaviour:
- FSM states: CORE, HALT, DMA, TURN.
- Reset (async, reset=0): state=CORE, core_rdy=1, dma_gnt=0, bus_owner=0, burst_cnt=0, cool_cnt=0. Reset asserted mid-burst returns to CORE immediately, and the core regains the bus.
- Bus mux: bus_owner=1 only in DMA; every other state drives core_address/core_data_out/core_read_en. core_data_in and dma_data_in are both mem_data_in, unregistered.
- CORE: core_rdy=1, dma_gnt=0. cool_cnt decrements toward 0, saturating.
  - Go to HALT when dma_req=1, cool_cnt=0 and core_read_en=1, all sampled at the edge.
  - A core write cycle defers the halt (6502 issues at most 3 consecutive writes).
- HALT: core_rdy=0 and the core keeps presenting its frozen read, mem_read_en=1.
  - dma_req=1 -> DMA, burst_cnt=0.
  - dma_req=0 -> TURN (abort, no grant issued).
- DMA: dma_gnt=1, bus_owner=1, burst_cnt increments each cycle.
  - Go to TURN when dma_req=0 or burst_cnt=MAX_BURST-1, i.e. exactly MAX_BURST DMA cycles maximum.
  - A DMA write occupies one cycle, same as a read.
- TURN: dma_gnt=0, core_rdy=0, bus back to core (core re-issues its stalled read). Load cool_cnt=MIN_CORE, then go to CORE.
- Latency: the edge sampling dma_req (with core read) enters HALT; dma_gnt rises at the next edge. Minimum request-to-grant is 2 cycles.
- core_rdy=0 spans HALT + DMA + TURN, i.e. 2 + burst length cycles.
- dma_req held continuously gives fairness: MAX_BURST DMA cycles, then at least MIN_CORE+1 core cycles (more if the core is writing), repeating.
- MIN_CORE=0: re-halt is allowed on the first CORE cycle.
- MAX_BURST=1: DMA lasts exactly one cycle.
- Counters are 8 bits wide, with no wrap beyond their bounds.

Decomposition:
- Package hmc_bus_pkg holds:
  - the state enum (CORE, HALT, DMA, TURN), 2 bits;
  - the owner encoding constants OWNER_CORE=0, OWNER_DMA=1.
- Sub-module arb_counter: 8-bit loadable up/down counter with saturate and terminal-count flag. It is instantiated twice, once for burst_cnt and once for cool_cnt.

Test Plan:
- Reset release, no dma_req -> core_rdy=1, dma_gnt=0, mem_address follows core_address (e.g. 16'h8000) every cycle.
- dma_req=1 while the core reads 16'h0200 -> HALT next cycle with mem_address=16'h0200; dma_gnt=1 the following cycle; mem_address=dma_address=16'h4014.
- dma_req=1 during 3 core write cycles -> no halt until the first core read; core_rdy stays 1 throughout the writes.
- dma_req held continuously with MAX_BURST=4, MIN_CORE=2 -> 4 cycles of dma_gnt=1, TURN, at least 2 CORE cycles, repeat; count of 4 checked over 3 bursts.
- dma_req dropped in HALT -> TURN then CORE, dma_gnt never asserted, core_rdy low exactly 2 cycles.
- reset asserted during a DMA write of 8'hA5 to 16'h2004 -> asynchronous return: bus_owner=0, dma_gnt=0, core_rdy=1 before the next edge.
